bp_rr_arb: RTL and testbench

//  Round-robin arbiter that shares one ready/valid backpressured stream between NREQ requesters.
//  It sits in front of a shared backpressured pipeline (e.g. a bp_pipe instance) and forwards
//  one beat per cycle, together with the source ID.

---
 rtl/bp_rr_arb_if.sv | 28 ++
 rtl/bp_rr_arb.sv | 112 +++++++++++
 tb/tb_bp_rr_arb.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_rr_arb_if.sv
// Handshake bundle for bp_rr_arb: NREQ requester lanes in, one granted lane out.
// Ports: req_data_i/req_valid_i/req_last_i/req_ready_o per requester, out_* downstream.
interface bp_rr_arb_if #(
    parameter int NREQ  = 4,
    parameter int DATAW = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0][DATAW-1:0] req_data_i;
    logic [NREQ-1:0]            req_valid_i;
    logic [NREQ-1:0]            req_last_i;
    logic [NREQ-1:0]            req_ready_o;
    logic [DATAW-1:0]           out_data_o;
    logic [IDW-1:0]             out_id_o;
    logic                       out_last_o;
    logic                       out_valid_o;
    logic                       out_ready_i;

    modport slave (
        input  req_data_i, req_valid_i, req_last_i, out_ready_i,
        output req_ready_o, out_data_o, out_id_o, out_last_o, out_valid_o
    );

    modport master (
        output req_data_i, req_valid_i, req_last_i, out_ready_i,
        input  req_ready_o, out_data_o, out_id_o, out_last_o, out_valid_o
    );
endinterface

// File: rtl/bp_rr_arb.sv
// Round-robin packet arbiter: NREQ ready/valid requesters onto one stream + source id.
// Ports: clk_i, rst_i (sync, active high), bus (bp_rr_arb_if.slave). Option: BP_ARB_OUT_REG_EN.
module bp_rr_arb #(
    parameter int NREQ  = 4,
    parameter int DATAW = 8
) (
    input logic         clk_i,
    input logic         rst_i,
    bp_rr_arb_if.slave  bus
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic [IDW-1:0]   ptr;
    logic             lock;
    logic [IDW-1:0]   lock_id;

    logic [IDW-1:0]   rr_id;
    logic             rr_hit;
    logic [IDW-1:0]   cand;
    int               idx;

    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   ptr_nxt;
    logic             arb_valid;
    logic             arb_ready;
    logic             arb_last;
    logic [DATAW-1:0] arb_data;

    // First valid requester at or after ptr, wrapping; idx stays below 2*NREQ
    // so a single subtraction keeps it in range for any NREQ.
    always_comb begin
        rr_hit = 1'b0;
        rr_id  = '0;
        idx    = 0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (!rr_hit && bus.req_valid_i[cand]) begin
                rr_hit = 1'b1;
                rr_id  = cand;
            end
        end
    end

    assign grant     = lock ? lock_id : rr_id;
    assign arb_valid = ~rst_i & bus.req_valid_i[grant];
    assign arb_data  = bus.req_data_i[grant];
    assign arb_last  = bus.req_last_i[grant];
    assign ptr_nxt   = (grant == LAST_ID) ? '0 : grant + IDW'(1);

    // With no lock and nobody asking there is no grant, so nobody is readied.
    assign bus.req_ready_o = (rst_i | ~(lock | rr_hit)) ?
                             '0 : (NREQ'(arb_ready) << grant);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr     <= '0;
            lock    <= 1'b0;
            lock_id <= '0;
        end else if (arb_valid) begin
            if (arb_ready && arb_last) begin
                lock <= 1'b0;
                ptr  <= ptr_nxt;
            end else begin
                // Mid-packet or stalled: hold the grant on this requester.
                lock    <= 1'b1;
                lock_id <= grant;
            end
        end
    end

`ifdef BP_ARB_OUT_REG_EN
    logic             s_valid;
    logic [DATAW-1:0] s_data;
    logic [IDW-1:0]   s_id;
    logic             s_last;

    // Slice accepts whenever it is empty or being drained this cycle.
    assign arb_ready = ~s_valid | bus.out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_valid <= 1'b0;
        end else if (arb_ready) begin
            s_valid <= arb_valid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && arb_ready && arb_valid) begin
            s_data <= arb_data;
            s_id   <= grant;
            s_last <= arb_last;
        end
    end

    assign bus.out_valid_o = s_valid & ~rst_i;
    assign bus.out_data_o  = s_data;
    assign bus.out_id_o    = s_id;
    assign bus.out_last_o  = s_last;
`else
    assign arb_ready       = bus.out_ready_i;
    assign bus.out_valid_o = arb_valid;
    assign bus.out_data_o  = arb_data;
    assign bus.out_id_o    = grant;
    assign bus.out_last_o  = arb_last;
`endif

endmodule

// File: tb/tb_bp_rr_arb.sv
// Scoreboard bench for bp_rr_arb: directed scenarios plus randomized traffic.
// A packet-level reference model predicts grants; a monitor checks output beats.
module tb_bp_rr_arb;
    localparam int NREQ  = 4;
    localparam int DATAW = 8;
    localparam int DEPTH = 1024;

    typedef struct {
        int             id;
        logic [DATAW-1:0] d;
        logic           l;
    } beat_t;

    bit   clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bp_rr_arb_if #(.NREQ(NREQ), .DATAW(DATAW)) bus ();

    bp_rr_arb #(.NREQ(NREQ), .DATAW(DATAW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tot = 0;
    int bad = 0;

    logic [DATAW:0] mem [NREQ][DEPTH];
    int             hd [NREQ];
    int             tl [NREQ];
    bit             vld [NREQ];
    bit             pend [NREQ];
    logic [DATAW:0] pfront [NREQ];

    // Reference state: which requester owns the stream mid-packet (-1 none),
    // where the round-robin search starts, and beats held in the output slice.
    int owner = -1;
    int rr    = 0;
    int bufc  = 0;
    int pv    = 100;
    int nact  = 0;

    beat_t exp_q [$];
    beat_t mon_e;
    int    obs [$];
    int    want [$];

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] wnt);
        tot++;
        if (got !== wnt) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, wnt);
        end
    endfunction

    function automatic logic [DATAW:0] front(int r);
        if (hd[r] == tl[r]) return '0;
        return mem[r][hd[r] % DEPTH];
    endfunction

    task automatic add_pkt(int r, int n);
        for (int k = 0; k < n; k++) begin
            mem[r][tl[r] % DEPTH] = {1'(k == n - 1), DATAW'($urandom)};
            tl[r]++;
        end
    endtask

    function automatic bit all_empty();
        for (int r = 0; r < NREQ; r++)
            if (hd[r] != tl[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cyc(input bit rdy, input bit r_in);
        int             pg;
        bit             pok;
        bit             ar;
        bit             xf;
        logic [NREQ-1:0] act;
        logic [NREQ-1:0] er;
        logic [DATAW:0]  fb;
        pg  = -1;
        pok = 1'b0;
        xf  = 1'b0;
        fb  = '0;
        @(negedge clk);
        rst = r_in;
        bus.out_ready_i = rdy;
        for (int r = 0; r < NREQ; r++) begin
            if (hd[r] != tl[r] && !vld[r] && $urandom_range(99) < pv)
                vld[r] = 1'b1;
            bus.req_valid_i[r] = vld[r];
            {bus.req_last_i[r], bus.req_data_i[r]} = front(r);
            if (pend[r])
                assert (vld[r] && front(r) == pfront[r])
                else $error("FAIL protocol: req %0d changed before transfer", r);
        end
        #1;
        act = bus.req_valid_i & bus.req_ready_o;
        if (r_in) begin
            chk("rst_req_ready", 32'(bus.req_ready_o), 0);
            chk("rst_out_valid", 32'(bus.out_valid_o), 0);
        end else begin
            if (owner >= 0) pg = owner;
            else
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (rr + k) % NREQ;
                    if (pg < 0 && vld[i]) pg = i;
                end
            pok = (pg >= 0) && vld[pg];
            if (pg >= 0) fb = front(pg);
`ifdef BP_ARB_OUT_REG_EN
            ar = (bufc == 0) || rdy;
`else
            ar = rdy;
`endif
            er = (pg >= 0 && ar) ? (NREQ'(1) << pg) : '0;
            chk("req_ready", 32'(bus.req_ready_o), 32'(er));
`ifdef BP_ARB_OUT_REG_EN
            chk("out_valid", 32'(bus.out_valid_o), 32'(bufc != 0));
`else
            chk("out_valid", 32'(bus.out_valid_o), 32'(pok));
            if (pok) begin
                chk("out_id", 32'(bus.out_id_o), 32'(pg));
                chk("out_data", 32'(bus.out_data_o), 32'(fb[DATAW-1:0]));
                chk("out_last", 32'(bus.out_last_o), 32'(fb[DATAW]));
            end
`endif
            xf = pok && ar;
            if (xf) exp_q.push_back('{id: pg, d: fb[DATAW-1:0], l: fb[DATAW]});
        end
        @(posedge clk);
        for (int r = 0; r < NREQ; r++)
            if (act[r]) begin
                hd[r]++;
                vld[r] = 1'b0;
                nact++;
            end
        if (r_in) begin
            owner = -1;
            rr    = 0;
            bufc  = 0;
            exp_q.delete();
            for (int r = 0; r < NREQ; r++) begin
                hd[r]  = tl[r];
                vld[r] = 1'b0;
            end
        end else begin
            if (xf) begin
                if (fb[DATAW]) begin
                    owner = -1;
                    rr    = (pg + 1) % NREQ;
                end else owner = pg;
            end else if (pok) owner = pg;
`ifdef BP_ARB_OUT_REG_EN
            if (ar) bufc = xf ? 1 : 0;
`endif
        end
        for (int r = 0; r < NREQ; r++) begin
            pend[r]   = vld[r];
            pfront[r] = front(r);
        end
    endtask

    task automatic drain(int n);
        int c;
        c = 0;
        while ((!all_empty() || exp_q.size() != 0) && c < n) begin
            cyc(1'b1, 1'b0);
            c++;
        end
        if (c >= n) begin
            tot++;
            bad++;
            $display("FAIL drain: still busy after %0d cycles, want empty", c);
        end
    endtask

    task automatic chk_seq(string nm);
        chk({nm, "_count"}, 32'(obs.size() >= want.size()), 1);
        for (int i = 0; i < want.size(); i++)
            if (i < obs.size()) chk(nm, 32'(obs[i]), 32'(want[i]));
    endtask

    // Monitor: every downstream handshake must match the oldest predicted beat.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tot++;
                    bad++;
                    $display("FAIL unexpected_beat: got id %0d want none", bus.out_id_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("mon_id", 32'(bus.out_id_o), 32'(mon_e.id));
                    chk("mon_data", 32'(bus.out_data_o), 32'(mon_e.d));
                    chk("mon_last", 32'(bus.out_last_o), 32'(mon_e.l));
                    obs.push_back(int'(bus.out_id_o));
                end
            end
        end
    end

    initial begin
        bus.out_ready_i = 1'b0;
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        bus.req_data_i  = '0;
        for (int r = 0; r < NREQ; r++) begin
            hd[r]   = 0;
            tl[r]   = 0;
            vld[r]  = 1'b0;
            pend[r] = 1'b0;
        end

        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);

        obs.delete();
        for (int r = 0; r < NREQ; r++) add_pkt(r, 1);
        for (int r = 0; r < NREQ; r++) add_pkt(r, 1);
        repeat (6) cyc(1'b1, 1'b0);
        drain(20);
        want = '{0, 1, 2, 3, 0, 1};
        chk_seq("rr_sweep");

        cyc(1'b1, 1'b1);
        obs.delete();
        add_pkt(1, 3);
        add_pkt(2, 1);
        drain(20);
        want = '{1, 1, 1, 2};
        chk_seq("pkt_lock");

        cyc(1'b1, 1'b1);
        obs.delete();
        add_pkt(0, 1);
        add_pkt(3, 1);
        repeat (3) cyc(1'b0, 1'b0);
        drain(20);
        want = '{0, 3};
        chk_seq("backpressure");

        cyc(1'b1, 1'b1);
        obs.delete();
        repeat (5) add_pkt(2, 1);
        nact = 0;
        repeat (5) cyc(1'b1, 1'b0);
        chk("solo_beats", 32'(nact), 5);
        drain(20);
        want = '{2, 2, 2, 2, 2};
        chk_seq("solo");

        cyc(1'b1, 1'b1);
        obs.delete();
        add_pkt(1, 3);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        add_pkt(0, 1);
        add_pkt(1, 1);
        drain(20);
        chk("rst_mid_count", 32'(obs.size() >= 2), 1);
        if (obs.size() >= 2) begin
            chk("rst_mid_first", 32'(obs[obs.size()-2]), 0);
            chk("rst_mid_second", 32'(obs[obs.size()-1]), 1);
        end

        cyc(1'b1, 1'b1);
        pv = 40;
        repeat (3000) begin
            for (int r = 0; r < NREQ; r++)
                if (hd[r] == tl[r] && $urandom_range(9) == 0)
                    add_pkt(r, int'($urandom_range(4, 1)));
            cyc($urandom_range(3) != 0, $urandom_range(499) == 0);
        end
        pv = 100;
        drain(500);
        chk("final_scoreboard_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
